// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces the row
// returns and emits one keystrobe plus a 4-bit keycode per accepted press.
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat of the held key.
module keypad_scanner #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int REPEAT_DELAY    = 5000000,
   parameter int REPEAT_PERIOD   = 1000000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic       keystrobe,
   output logic [3:0] keycode,
   output logic       key_held
);

   // Reject parameter values the timing scheme cannot support.
   if (SCAN_DIV < 4) begin : g_chk_scan_div
      $error("keypad_scanner: SCAN_DIV must be at least 4");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
      $error("keypad_scanner: DEBOUNCE_CYCLES must be at least 2");
   end
   if ((REPEAT_DELAY < 2) || (REPEAT_PERIOD < 2)) begin : g_chk_repeat
      $error("keypad_scanner: repeat intervals must be at least 2");
   end

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_SCAN       = 2'd0,
      ST_PRESS_DB   = 2'd1,
      ST_HELD       = 2'd2,
      ST_RELEASE_DB = 2'd3
   } state_t;

   state_t           state_r;
   logic [3:0]       row_meta_r;
   logic [3:0]       row_sync_r;
   logic [1:0]       col_idx_r;
   logic [1:0]       cap_row_r;
   logic [DIV_W-1:0] div_cnt_r;
   logic [DB_W-1:0]  db_cnt_r;

`ifdef KEYPAD_REPEAT_EN
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = $clog2(RP_MAX);
   localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);
   logic [RP_W-1:0] rep_cnt_r;
   logic            rep_first_r;
`endif

   // Lowest-index active (low) row; caller guarantees at least one is low.
   function automatic logic [1:0] low_row(input logic [3:0] rows);
      logic [1:0] idx;
      if (rows[0] == 1'b0) begin
         idx = 2'd0;
      end else if (rows[1] == 1'b0) begin
         idx = 2'd1;
      end else if (rows[2] == 1'b0) begin
         idx = 2'd2;
      end else begin
         idx = 2'd3;
      end
      return idx;
   endfunction

   // One-hot active-low column drive for a column index.
   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      logic [3:0] drv;
      case (idx)
         2'd0:    drv = 4'b1110;
         2'd1:    drv = 4'b1101;
         2'd2:    drv = 4'b1011;
         2'd3:    drv = 4'b0111;
         default: drv = 4'b1111;
      endcase
      return drv;
   endfunction

   // Keycode for a row/column position, as the downstream decoder expects.
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'b00_00: code = 4'd1;
         4'b00_01: code = 4'd2;
         4'b00_10: code = 4'd3;
         4'b00_11: code = 4'd15;
         4'b01_00: code = 4'd4;
         4'b01_01: code = 4'd5;
         4'b01_10: code = 4'd6;
         4'b01_11: code = 4'd14;
         4'b10_00: code = 4'd7;
         4'b10_01: code = 4'd8;
         4'b10_10: code = 4'd9;
         4'b10_11: code = 4'd13;
         4'b11_00: code = 4'd10;
         4'b11_01: code = 4'd0;
         4'b11_10: code = 4'd11;
         4'b11_11: code = 4'd12;
         default:  code = 4'd0;
      endcase
      return code;
   endfunction

   // Two-flop synchroniser for the asynchronous row returns.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         row_meta_r <= 4'hF;
         row_sync_r <= 4'hF;
      end else begin
         row_meta_r <= row_n;
         row_sync_r <= row_meta_r;
      end
   end

   // Scan / debounce state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r     <= ST_SCAN;
         col_idx_r   <= 2'd0;
         col_n       <= 4'b1110;
         cap_row_r   <= 2'd0;
         div_cnt_r   <= '0;
         db_cnt_r    <= '0;
         keystrobe   <= 1'b0;
         keycode     <= 4'd0;
         key_held    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt_r   <= '0;
         rep_first_r <= 1'b1;
`endif
      end else begin
         keystrobe <= 1'b0;
         case (state_r)
            ST_SCAN: begin
               if (div_cnt_r == DIV_LAST) begin
                  div_cnt_r <= '0;
                  if (row_sync_r != 4'hF) begin
                     // The sample cycle is the first low cycle of the debounce.
                     cap_row_r <= low_row(row_sync_r);
                     db_cnt_r  <= DB_W'(1);
                     state_r   <= ST_PRESS_DB;
                  end else begin
                     col_idx_r <= col_idx_r + 2'd1;
                     col_n     <= col_drive(col_idx_r + 2'd1);
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + DIV_W'(1);
               end
            end
            ST_PRESS_DB: begin
               if (row_sync_r[cap_row_r] == 1'b0) begin
                  if (db_cnt_r == DB_LAST) begin
                     keycode   <= key_map(cap_row_r, col_idx_r);
                     keystrobe <= 1'b1;
                     key_held  <= 1'b1;
                     state_r   <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                     rep_cnt_r   <= '0;
                     rep_first_r <= 1'b1;
`endif
                  end else begin
                     db_cnt_r <= db_cnt_r + DB_W'(1);
                  end
               end else begin
                  // Bounce: give up on this key and move on to the next column.
                  state_r   <= ST_SCAN;
                  div_cnt_r <= '0;
                  col_idx_r <= col_idx_r + 2'd1;
                  col_n     <= col_drive(col_idx_r + 2'd1);
               end
            end
            ST_HELD: begin
               if (row_sync_r == 4'hF) begin
                  // The cycle that sees all rows high counts toward release.
                  db_cnt_r <= DB_W'(1);
                  state_r  <= ST_RELEASE_DB;
               end else begin
`ifdef KEYPAD_REPEAT_EN
                  if (rep_cnt_r == (rep_first_r ? DELAY_LAST : PERIOD_LAST)) begin
                     keystrobe   <= 1'b1;
                     rep_cnt_r   <= '0;
                     rep_first_r <= 1'b0;
                  end else begin
                     rep_cnt_r <= rep_cnt_r + RP_W'(1);
                  end
`else
                  state_r <= ST_HELD;
`endif
               end
            end
            ST_RELEASE_DB: begin
               if (row_sync_r == 4'hF) begin
                  if (db_cnt_r == DB_LAST) begin
                     key_held  <= 1'b0;
                     state_r   <= ST_SCAN;
                     div_cnt_r <= '0;
                     col_idx_r <= col_idx_r + 2'd1;
                     col_n     <= col_drive(col_idx_r + 2'd1);
                  end else begin
                     db_cnt_r <= db_cnt_r + DB_W'(1);
                  end
               end else begin
                  state_r <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                  rep_cnt_r   <= '0;
                  rep_first_r <= 1'b0;
`endif
               end
            end
            default: begin
               state_r <= ST_SCAN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner.
// Models the keypad as switches connecting a column line to a row line.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic       keystrobe;
   logic [3:0] keycode;
   logic       key_held;

   logic [3:0] raw_n = 4'hF;
   bit         key_en [2];
   int         key_r  [2];
   int         key_c  [2];

   int errors  = 0;
   int checks  = 0;
   int cyc     = 0;
   int nstrobe = 0;
   int strobe_cyc [$];

`ifdef KEYPAD_REPEAT_EN
   int exp_off [$] = '{0, 40, 56, 72, 88};
`else
   int exp_off [$] = '{0};
`endif

   keypad_scanner #(
      .SCAN_DIV        (4),
      .DEBOUNCE_CYCLES (8),
      .REPEAT_DELAY    (40),
      .REPEAT_PERIOD   (16)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .row_n     (row_n),
      .col_n     (col_n),
      .keystrobe (keystrobe),
      .keycode   (keycode),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Pressed keys short their row to the column while that column is driven low.
   always_comb begin
      row_n = raw_n;
      for (int k = 0; k < 2; k++) begin
         if (key_en[k] && (col_n[key_c[k]] == 1'b0)) begin
            row_n[key_r[k]] = 1'b0;
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, sampling on the falling edge and logging strobes.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (keystrobe === 1'b1) begin
         nstrobe++;
         strobe_cyc.push_back(cyc);
      end
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic wait_strobe(input int lim, input string tag);
      int s0;
      int i;
      s0 = nstrobe;
      i  = 0;
      while ((nstrobe == s0) && (i < lim)) begin
         step();
         i++;
      end
      check(tag, 32'(nstrobe - s0), 32'd1);
   endtask

   task automatic wait_release(input int lim, input string tag);
      int i;
      i = 0;
      while ((key_held === 1'b1) && (i < lim)) begin
         step();
         i++;
      end
      check(tag, 32'(key_held), 32'd0);
   endtask

   initial begin
      int s0;
      int a;
      int i;

      // Reset held for 3 cycles
      resetn = 1'b0;
      steps(3);
      check("rst_col",    32'(col_n),     32'h0000000E);
      check("rst_strobe", 32'(keystrobe), 32'd0);
      check("rst_code",   32'(keycode),   32'd0);
      check("rst_held",   32'(key_held),  32'd0);
      resetn = 1'b1;
      steps(3);
      check("scan_c0_dwell", 32'(col_n), 32'h0000000E);
      steps(1);
      check("scan_c1", 32'(col_n), 32'h0000000D);
      steps(4);
      check("scan_c2", 32'(col_n), 32'h0000000B);
      steps(4);
      check("scan_c3", 32'(col_n), 32'h00000007);
      steps(4);
      check("scan_wrap", 32'(col_n), 32'h0000000E);

      // Press r1/c2 -> keycode 6
      s0 = nstrobe;
      key_r[0] = 1; key_c[0] = 2; key_en[0] = 1'b1;
      wait_strobe(40, "p6_strobe");
      check("p6_code", 32'(keycode),  32'd6);
      check("p6_held", 32'(key_held), 32'd1);
      step();
      check("p6_pulse_width", 32'(keystrobe), 32'd0);
      steps(12);
      check("p6_one_strobe", 32'(nstrobe - s0), 32'd1);
      check("p6_col_kept",   32'(col_n),        32'h0000000B);
      key_en[0] = 1'b0;
      steps(9);
      check("p6_held_before_release", 32'(key_held), 32'd1);
      step();
      check("p6_release",    32'(key_held), 32'd0);
      check("p6_resume_col", 32'(col_n),    32'h00000007);

      // Bounce on row 0 across a column-0 sample
      s0 = nstrobe;
      steps(4);
      raw_n = 4'b1110;
      steps(3);
      raw_n = 4'hF;
      steps(3);
      check("bounce_next_col", 32'(col_n),    32'h0000000D);
      check("bounce_held",     32'(key_held), 32'd0);
      steps(20);
      check("bounce_no_strobe", 32'(nstrobe - s0), 32'd0);
      check("bounce_code_kept", 32'(keycode),      32'd6);

      // Rows 0 and 2 together in column 0 -> lowest row wins
      s0 = nstrobe;
      key_r[0] = 0; key_c[0] = 0; key_en[0] = 1'b1;
      key_r[1] = 2; key_c[1] = 0; key_en[1] = 1'b1;
      wait_strobe(40, "prio_strobe");
      check("prio_code", 32'(keycode), 32'd1);
      steps(5);
      check("prio_one_strobe", 32'(nstrobe - s0), 32'd1);
      key_en[0] = 1'b0;
      key_en[1] = 1'b0;
      wait_release(20, "prio_release");

      // Operator key r1/c3 -> keycode 14
      s0 = nstrobe;
      key_r[0] = 1; key_c[0] = 3; key_en[0] = 1'b1;
      wait_strobe(40, "op_strobe");
      check("op_code", 32'(keycode), 32'd14);
      steps(5);
      check("op_one_strobe", 32'(nstrobe - s0), 32'd1);
      key_en[0] = 1'b0;
      wait_release(20, "op_release");

      // Reset during the 4th press-debounce cycle of r2/c1
      s0 = nstrobe;
      key_r[0] = 2; key_c[0] = 1; key_en[0] = 1'b1;
      i = 0;
      while ((col_n !== 4'b1101) && (i < 20)) begin
         step();
         i++;
      end
      check("mid_reach_col1", 32'(col_n), 32'h0000000D);
      steps(6);
      resetn = 1'b0;
      step();
      check("mid_rst_strobe", 32'(keystrobe), 32'd0);
      check("mid_rst_held",   32'(key_held),  32'd0);
      check("mid_rst_col",    32'(col_n),     32'h0000000E);
      check("mid_rst_code",   32'(keycode),   32'd0);
      key_en[0] = 1'b0;
      steps(2);
      resetn = 1'b1;
      steps(20);
      check("mid_rst_no_strobe", 32'(nstrobe - s0), 32'd0);

      // Long hold of r3/c1 (keycode 0) for 100 cycles from accept
      s0 = nstrobe;
      key_r[0] = 3; key_c[0] = 1; key_en[0] = 1'b1;
      wait_strobe(60, "hold_strobe");
      a = cyc;
      steps(99);
      key_en[0] = 1'b0;
      wait_release(30, "hold_release");
      check("hold_strobe_count", 32'(nstrobe - s0), 32'(exp_off.size()));
      for (int k = 0; k < exp_off.size(); k++) begin
         if ((s0 + k) < strobe_cyc.size()) begin
            check($sformatf("hold_offset_%0d", k), 32'(strobe_cyc[s0 + k] - a), 32'(exp_off[k]));
         end
      end
      check("hold_code", 32'(keycode), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
